// File: rtl/tracker_pkg.sv
// Shared widths and FSM encoding for the centroid tracker.
// Imported by the divider and the tracker top.
package tracker_pkg;
  localparam int COORD_W = 10;
  localparam int CNT_W   = 19;
  localparam int SUM_W   = 28;

  typedef enum logic [1:0] {
    IDLE,
    DIVIDE,
    PUBLISH
  } state_t;
endpackage

// File: rtl/seq_divider.sv
// Restoring divider, one quotient bit per clock, SUM_W iterations.
// Quotient is presented truncated to the coordinate width.
module seq_divider
  import tracker_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               i_start,
  input  logic [SUM_W-1:0]   i_dividend,
  input  logic [CNT_W-1:0]   i_divisor,
  output logic [COORD_W-1:0] o_quotient,
  output logic               o_done
);
  localparam logic [4:0] ITERS = 5'(SUM_W);

  logic [SUM_W-1:0] r_q;
  logic [CNT_W-1:0] r_rem;
  logic [CNT_W-1:0] r_div;
  logic [4:0]       r_cnt;
  logic             r_busy;
  logic             r_done;

  logic [CNT_W:0] w_shift;
  logic [CNT_W:0] w_diff;
  logic           w_ge;

  assign w_shift = {r_rem, r_q[SUM_W-1]};
  assign w_ge    = w_shift >= {1'b0, r_div};
  assign w_diff  = w_shift - {1'b0, r_div};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q    <= '0;
      r_rem  <= '0;
      r_div  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else if (i_start) begin
      r_q    <= i_dividend;
      r_rem  <= '0;
      r_div  <= i_divisor;
      r_cnt  <= ITERS;
      r_busy <= 1'b1;
      r_done <= 1'b0;
    end else if (r_busy) begin
      // a zero divisor yields all-ones; the caller discards it
      r_rem <= w_ge ? w_diff[CNT_W-1:0] : w_shift[CNT_W-1:0];
      r_q   <= {r_q[SUM_W-2:0], w_ge};
      r_cnt <= r_cnt - 5'd1;
      if (r_cnt == 5'd1) begin
        r_busy <= 1'b0;
        r_done <= 1'b1;
      end
    end
  end

  assign o_quotient = r_q[COORD_W-1:0];
  assign o_done     = r_done;
endmodule

// File: rtl/target_centroid_tracker.sv
// Per-frame target-pixel accumulator with snapshot, dual divider
// and a publish stage that updates results once per frame.
module target_centroid_tracker
  import tracker_pkg::*;
#(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int MIN_PIXELS = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               DE,
  input  logic [COORD_W-1:0] x_pixel,
  input  logic [COORD_W-1:0] y_pixel,
  input  logic               is_target_color,
  output logic [COORD_W-1:0] centroid_x,
  output logic [COORD_W-1:0] centroid_y,
  output logic [COORD_W-1:0] bbox_x_min,
  output logic [COORD_W-1:0] bbox_x_max,
  output logic [COORD_W-1:0] bbox_y_min,
  output logic [COORD_W-1:0] bbox_y_max,
  output logic [CNT_W-1:0]   pixel_count,
  output logic               obj_valid,
  output logic               result_valid,
  output logic               busy
);
  localparam logic [COORD_W-1:0] XL   = COORD_W'(H_ACTIVE - 1);
  localparam logic [COORD_W-1:0] YL   = COORD_W'(V_ACTIVE - 1);
  localparam logic [CNT_W-1:0]   MINC = CNT_W'(MIN_PIXELS);

  state_t r_state, w_next;

  logic [CNT_W-1:0]   r_cnt, r_scnt, w_cnt;
  logic [SUM_W-1:0]   r_sx, r_sy, r_ssx, r_ssy, w_sx, w_sy;
  logic [COORD_W-1:0] r_xmin, r_xmax, r_ymin, r_ymax;
  logic [COORD_W-1:0] r_sxmin, r_sxmax, r_symin, r_symax;
  logic [COORD_W-1:0] w_xmin, w_xmax, w_ymin, w_ymax;
  logic [COORD_W-1:0] r_cx, r_cy, r_bx0, r_bx1, r_by0, r_by1;
  logic [COORD_W-1:0] w_qx, w_qy;
  logic [CNT_W-1:0]   r_pc;
  logic               r_ov, r_rv, r_loaded;
  logic               w_hit, w_fend, w_start, w_pub;
  logic               w_dx_done, w_dy_done;

  assign w_hit  = DE && is_target_color && x_pixel <= XL && y_pixel <= YL;
  assign w_fend = DE && x_pixel == XL && y_pixel == YL;

  // live values including the pixel sampled on this edge
  always_comb begin
    w_cnt  = r_cnt;
    w_sx   = r_sx;
    w_sy   = r_sy;
    w_xmin = r_xmin;
    w_xmax = r_xmax;
    w_ymin = r_ymin;
    w_ymax = r_ymax;
    if (w_hit) begin
      w_cnt = r_cnt + CNT_W'(1);
      w_sx  = r_sx + SUM_W'(x_pixel);
      w_sy  = r_sy + SUM_W'(y_pixel);
      if (x_pixel < r_xmin) w_xmin = x_pixel;
      if (x_pixel > r_xmax) w_xmax = x_pixel;
      if (y_pixel < r_ymin) w_ymin = y_pixel;
      if (y_pixel > r_ymax) w_ymax = y_pixel;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset || w_fend) begin
      r_cnt  <= '0;
      r_sx   <= '0;
      r_sy   <= '0;
      r_xmin <= '1;
      r_xmax <= '0;
      r_ymin <= '1;
      r_ymax <= '0;
    end else begin
      r_cnt  <= w_cnt;
      r_sx   <= w_sx;
      r_sy   <= w_sy;
      r_xmin <= w_xmin;
      r_xmax <= w_xmax;
      r_ymin <= w_ymin;
      r_ymax <= w_ymax;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_scnt  <= '0;
      r_ssx   <= '0;
      r_ssy   <= '0;
      r_sxmin <= '0;
      r_sxmax <= '0;
      r_symin <= '0;
      r_symax <= '0;
    end else if (w_fend && r_state == IDLE) begin
      r_scnt  <= w_cnt;
      r_ssx   <= w_sx;
      r_ssy   <= w_sy;
      r_sxmin <= w_xmin;
      r_sxmax <= w_xmax;
      r_symin <= w_ymin;
      r_symax <= w_ymax;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_loaded <= 1'b0;
    end else begin
      r_state  <= w_next;
      if (w_start)
        r_loaded <= 1'b1;
      else if (r_state != DIVIDE)
        r_loaded <= 1'b0;
    end
  end

  always_comb begin
    w_next  = r_state;
    w_start = 1'b0;
    w_pub   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_fend) w_next = DIVIDE;
      end
      DIVIDE: begin
        if (!r_loaded) begin
          w_start = 1'b1;
        end else if (w_dx_done && w_dy_done) begin
          w_pub  = 1'b1;
          w_next = PUBLISH;
        end
      end
      PUBLISH: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  seq_divider u_div_x (
    .clk        (clk),
    .reset      (reset),
    .i_start    (w_start),
    .i_dividend (r_ssx),
    .i_divisor  (r_scnt),
    .o_quotient (w_qx),
    .o_done     (w_dx_done)
  );

  seq_divider u_div_y (
    .clk        (clk),
    .reset      (reset),
    .i_start    (w_start),
    .i_dividend (r_ssy),
    .i_divisor  (r_scnt),
    .o_quotient (w_qy),
    .o_done     (w_dy_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cx  <= '0;
      r_cy  <= '0;
      r_bx0 <= '0;
      r_bx1 <= '0;
      r_by0 <= '0;
      r_by1 <= '0;
      r_pc  <= '0;
      r_ov  <= 1'b0;
      r_rv  <= 1'b0;
    end else begin
      r_rv <= w_pub;
      if (w_pub) begin
        r_pc <= r_scnt;
        r_ov <= r_scnt >= MINC;
        if (r_scnt >= MINC) begin
          r_cx  <= w_qx;
          r_cy  <= w_qy;
          r_bx0 <= r_sxmin;
          r_bx1 <= r_sxmax;
          r_by0 <= r_symin;
          r_by1 <= r_symax;
        end
      end
    end
  end

  assign centroid_x   = r_cx;
  assign centroid_y   = r_cy;
  assign bbox_x_min   = r_bx0;
  assign bbox_x_max   = r_bx1;
  assign bbox_y_min   = r_by0;
  assign bbox_y_max   = r_by1;
  assign pixel_count  = r_pc;
  assign obj_valid    = r_ov;
  assign result_valid = r_rv;
  assign busy         = r_state != IDLE;
endmodule

// File: tb/tb_target_centroid_tracker.sv
// Scoreboard bench: frame stimulus pushes expected results,
// monitors pop and compare on each result_valid pulse.
module tb_target_centroid_tracker;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       DE, tgt;
  logic [9:0] x_pixel, y_pixel;
  logic [9:0] cx, cy, bx0, bx1, by0, by1;
  logic [18:0] pc;
  logic       ov, rv, busy;

  logic       s_DE, s_tgt;
  logic [9:0] s_x, s_y;
  logic [9:0] s_cx, s_cy, s_bx0, s_bx1, s_by0, s_by1;
  logic [18:0] s_pc;
  logic       s_ov, s_rv, s_busy;

  target_centroid_tracker u_dut (
    .clk(clk), .reset(reset), .DE(DE),
    .x_pixel(x_pixel), .y_pixel(y_pixel),
    .is_target_color(tgt),
    .centroid_x(cx), .centroid_y(cy),
    .bbox_x_min(bx0), .bbox_x_max(bx1),
    .bbox_y_min(by0), .bbox_y_max(by1),
    .pixel_count(pc), .obj_valid(ov),
    .result_valid(rv), .busy(busy)
  );

  target_centroid_tracker #(
    .H_ACTIVE(40), .V_ACTIVE(30), .MIN_PIXELS(64)
  ) u_small (
    .clk(clk), .reset(reset), .DE(s_DE),
    .x_pixel(s_x), .y_pixel(s_y),
    .is_target_color(s_tgt),
    .centroid_x(s_cx), .centroid_y(s_cy),
    .bbox_x_min(s_bx0), .bbox_x_max(s_bx1),
    .bbox_y_min(s_by0), .bbox_y_max(s_by1),
    .pixel_count(s_pc), .obj_valid(s_ov),
    .result_valid(s_rv), .busy(s_busy)
  );

  typedef struct {
    int cnt, cx, cy, x0, x1, y0, y1, ov, t;
  } exp_t;

  exp_t q[$];
  exp_t sq[$];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int t_fe = 0;
  int h_cx = 0, h_cy = 0, h_x0 = 0, h_x1 = 0, h_y0 = 0, h_y1 = 0;

  always @(posedge clk) cyc++;

  function automatic void check(string nm, bit ok, string det);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: %s", nm, det);
    end
  endfunction

  function automatic void cmp(string nm, exp_t e, int c, int x, int y,
                              int a0, int a1, int b0, int b1, int v);
    bit ok;
    ok = c == e.cnt && x == e.cx && y == e.cy && a0 == e.x0 &&
         a1 == e.x1 && b0 == e.y0 && b1 == e.y1 && v == e.ov;
    check({nm, "_result"}, ok, $sformatf(
      "got cnt=%0d c=(%0d,%0d) bb=(%0d,%0d,%0d,%0d) ov=%0d required cnt=%0d c=(%0d,%0d) bb=(%0d,%0d,%0d,%0d) ov=%0d",
      c, x, y, a0, a1, b0, b1, v,
      e.cnt, e.cx, e.cy, e.x0, e.x1, e.y0, e.y1, e.ov));
    check({nm, "_latency"}, cyc == e.t,
      $sformatf("pulse at edge %0d required %0d", cyc, e.t));
  endfunction

  // expected result; centroid/bbox hold when the object is too small
  function automatic void push(int c, int x, int y,
                               int a0, int a1, int b0, int b1);
    exp_t e;
    if (c >= 64) begin
      h_cx = x; h_cy = y;
      h_x0 = a0; h_x1 = a1; h_y0 = b0; h_y1 = b1;
    end
    e = '{c, h_cx, h_cy, h_x0, h_x1, h_y0, h_y1,
          int'(c >= 64), t_fe + 30};
    q.push_back(e);
  endfunction

  always @(negedge clk) begin
    if (!reset && rv) begin
      if (q.size() == 0)
        check("main_spurious", 1'b0, "result_valid=1 required 0");
      else
        cmp("main", q.pop_front(), int'(pc), int'(cx), int'(cy),
            int'(bx0), int'(bx1), int'(by0), int'(by1), int'(ov));
    end
  end

  always @(negedge clk) begin
    if (!reset && s_rv) begin
      if (sq.size() == 0)
        check("small_spurious", 1'b0, "result_valid=1 required 0");
      else
        cmp("small", sq.pop_front(), int'(s_pc), int'(s_cx),
            int'(s_cy), int'(s_bx0), int'(s_bx1), int'(s_by0),
            int'(s_by1), int'(s_ov));
    end
  end

  task automatic drive(int x, int y, bit de, bit t);
    @(negedge clk);
    x_pixel = 10'(x);
    y_pixel = 10'(y);
    DE = de;
    tgt = t;
  endtask

  task automatic idle(int n);
    repeat (n) drive(0, 0, 1'b0, 1'b0);
  endtask

  task automatic block(int x0, int y0, int w, int h);
    for (int y = y0; y < y0 + h; y++)
      for (int x = x0; x < x0 + w; x++)
        drive(x, y, 1'b1, 1'b1);
  endtask

  task automatic fend(bit t);
    drive(639, 479, 1'b1, t);
    t_fe = cyc + 1;
  endtask

  task automatic chk_zero();
    check("rst_cx", cx == 0, $sformatf("got %0d required 0", cx));
    check("rst_cy", cy == 0, $sformatf("got %0d required 0", cy));
    check("rst_bbox", {bx0, bx1, by0, by1} == 40'd0,
          $sformatf("got %0d,%0d,%0d,%0d required 0", bx0, bx1, by0, by1));
    check("rst_count", pc == 0, $sformatf("got %0d required 0", pc));
    check("rst_flags", {ov, rv, busy} == 3'b000,
          $sformatf("got ov=%0d rv=%0d busy=%0d required 0", ov, rv, busy));
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && (q.size() > 0 || sq.size() > 0); i++)
      @(negedge clk);
    check("drain", q.size() == 0 && sq.size() == 0,
          $sformatf("%0d results outstanding required 0",
                    q.size() + sq.size()));
    q.delete();
    sq.delete();
  endtask

  initial begin
    reset = 1'b1;
    DE = 1'b0; tgt = 1'b0; x_pixel = '0; y_pixel = '0;
    s_DE = 1'b0; s_tgt = 1'b0; s_x = '0; s_y = '0;
    idle(3);
    chk_zero();
    reset = 1'b0;
    idle(3);

    block(100, 50, 10, 10);
    fend(1'b0);
    push(100, 104, 54, 100, 109, 50, 59);
    idle(1);
    check("busy_divide", busy == 1'b1,
          $sformatf("got %0d required 1", busy));
    idle(39);

    fend(1'b0);
    push(0, 0, 0, 0, 0, 0, 0);
    idle(40);

    drive(5, 5, 1'b1, 1'b1);
    fend(1'b0);
    push(1, 0, 0, 0, 0, 0, 0);
    idle(40);

    drive(700, 10, 1'b1, 1'b1);
    drive(5, 5, 1'b0, 1'b1);
    drive(800, 479, 1'b1, 1'b1);
    fend(1'b0);
    push(0, 0, 0, 0, 0, 0, 0);
    idle(40);

    for (int y = 472; y < 480; y++)
      for (int x = 632; x < 640; x++)
        if (!(x == 639 && y == 479)) drive(x, y, 1'b1, 1'b1);
    fend(1'b1);
    push(64, 635, 475, 632, 639, 472, 479);
    idle(40);

    for (int y = 472; y < 480; y++)
      for (int x = 632; x < 640; x++)
        if (!(x == 639 && y == 479)) drive(x, y, 1'b1, 1'b1);
    fend(1'b0);
    push(63, 0, 0, 0, 0, 0, 0);
    idle(40);

    block(100, 50, 10, 10);
    fend(1'b0);
    push(100, 104, 54, 100, 109, 50, 59);
    idle(5);
    drive(3, 3, 1'b1, 1'b1);
    fend(1'b0);
    idle(40);
    fend(1'b0);
    push(0, 0, 0, 0, 0, 0, 0);
    idle(40);
    drain();

    block(100, 50, 10, 10);
    fend(1'b0);
    idle(10);
    reset = 1'b1;
    idle(2);
    chk_zero();
    reset = 1'b0;
    h_cx = 0; h_cy = 0; h_x0 = 0; h_x1 = 0; h_y0 = 0; h_y1 = 0;
    idle(40);

    block(100, 50, 10, 10);
    fend(1'b0);
    push(100, 104, 54, 100, 109, 50, 59);
    idle(40);

    for (int y = 0; y < 30; y++)
      for (int x = 0; x < 40; x++) begin
        @(negedge clk);
        s_x = 10'(x);
        s_y = 10'(y);
        s_DE = 1'b1;
        s_tgt = 1'b1;
        if (x == 39 && y == 29)
          sq.push_back('{1200, 19, 14, 0, 39, 0, 29, 1, cyc + 31});
      end
    @(negedge clk);
    s_DE = 1'b0;
    s_tgt = 1'b0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/target_centroid_tracker.md
# target_centroid_tracker

Per-frame object locator fed by the colour-detection stage. It consumes the VGA raster coordinates, the display-enable and the per-pixel `is_target_color` flag. Over each active frame it accumulates the count, coordinate sums and bounding box of target pixels, then divides to produce a centroid. Results go to the collision/game logic, one result per frame during vertical blanking.

## Interface
Parameters:
- `H_ACTIVE`, 640: active pixels per line.
- `V_ACTIVE`, 480: active lines per frame.
- `MIN_PIXELS`, 64: minimum target-pixel count for a valid object.

Ports:
- `clk` in 1: pixel clock (25 MHz domain). One clock. Reset is asynchronous and active-high.
- `reset` in 1: asynchronous, active-high.
- `DE` in 1: display enable / pixel valid.
- `x_pixel` in 10: raster column.
- `y_pixel` in 10: raster row.
- `is_target_color` in 1: current pixel matches target colour.
- `centroid_x` out 10: floor(sum_x / count) of the last valid object.
- `centroid_y` out 10: floor(sum_y / count) of the last valid object.
- `bbox_x_min`, `bbox_x_max`, `bbox_y_min`, `bbox_y_max` out 10 each: bounding box of the last valid object.
- `pixel_count` out 19: target-pixel count of the last completed frame.
- `obj_valid` out 1: last completed frame had count ≥ MIN_PIXELS.
- `result_valid` out 1: one-cycle pulse when outputs update.
- `busy` out 1: division in progress.

## Operation
- A pixel is counted when `DE`=1, `x_pixel`<H_ACTIVE, `y_pixel`<V_ACTIVE and `is_target_color`=1. Any other pixel is ignored.
- Live accumulators per counted pixel:
  - count += 1 (19 b)
  - sum_x += x (28 b)
  - sum_y += y (28 b)
  - min/max of x and y updated
- These widths cannot overflow at 640×480.
- Frame end is the edge where the sampled pixel has `DE`=1, x=H_ACTIVE−1 and y=V_ACTIVE−1. On that edge:
  - live values, including this pixel's contribution, are copied to snapshot registers;
  - live accumulators clear to count 0, sums 0, min 10'h3FF, max 0.
- Accumulation never stalls. The next frame accumulates into the cleared live registers while the snapshot is processed.
- FSM states:
  - IDLE: on frame end, go to DIVIDE.
  - DIVIDE: two restoring dividers (x and y) run in parallel for 28 iterations. When both are done, go to PUBLISH.
  - PUBLISH: register outputs, pulse `result_valid`, return to IDLE.
- Snapshot count < MIN_PIXELS (including 0):
  - dividers still run (divide-by-zero result is discarded);
  - `centroid_*` and `bbox_*` hold their previous values;
  - `obj_valid`=0; `pixel_count` updates; `result_valid` still pulses.
- Count ≥ MIN_PIXELS: centroid, bbox and `pixel_count` update, and `obj_valid`=1.
- Quotients are truncated to 10 b; they are always < H_ACTIVE.
- A frame end that arrives while in DIVIDE or PUBLISH:
  - the snapshot is not overwritten and that frame's result is dropped;
  - live accumulators are still cleared.
- `busy`=1 in DIVIDE and PUBLISH.

## Timing
- Reset (asynchronous) sets all outputs to 0, clears live accumulators and snapshot, and enters IDLE. Reset asserted mid-DIVIDE aborts it with no `result_valid` pulse.
- Latency: frame-end edge T → `result_valid`=1 at edge T+30, consisting of:
  - 1 cycle to load the dividers;
  - 28 iterations;
  - 1 cycle to publish.
- All outputs change only on the `result_valid` edge and are stable until the next one.
- Vertical blanking (≥45 lines) far exceeds the 30-cycle latency, so normal operation never drops frames.

## Structure
- `tracker_pkg` holds:
  - `COORD_W`=10, `CNT_W`=19, `SUM_W`=28;
  - the `state_t` enum {IDLE, DIVIDE, PUBLISH}.
- Sub-module `seq_divider` (SUM_W-bit dividend, CNT_W-bit divisor, start/done handshake, 28-cycle restoring division), instantiated twice.
- Top level contains the accumulators, snapshot registers and FSM.

## Test plan
- 10×10 target block at x 100..109, y 50..59:
  - `result_valid` at T+30;
  - count 100, centroid (104,54), bbox (100,109,50,59), `obj_valid`=1.
- Next frame with no target pixels: count 0, `obj_valid`=0, centroid and bbox hold (104,54)/(100,109,50,59), `result_valid` still pulses.
- Single target pixel at (5,5), MIN_PIXELS=64: count 1, `obj_valid`=0, centroid unchanged.
- Full-screen target: count 307200, centroid (319,239), bbox (0,639,0,479).
- Target flag asserted with `DE`=0, or with x≥640: ignored, count 0.
- Reset asserted 10 cycles after frame end:
  - all outputs 0, no `result_valid`;
  - the following frame with the 10×10 block produces the correct result.
